friscv_apb_arbiter: RTL and testbench
=====================================

// Module: friscv_apb_arbiter
//
// PURPOSE
// Shares the single APB-like master port of friscv_apb_interconnect between NREQ requesters
// (e.g. data memory unit, debug module, DMA). Round-robin arbitration, one transfer in flight,
// fully registered outputs toward both the interconnect and the requesters.
//
// PARAMETERS
// NREQ   2   number of requesters, 2..8
// ADDRW  16  address width, matches interconnect
// XLEN   32  data width; strobe width XLEN/8
//
// PORTS
// aclk       in   1             clock; single clock domain
// srst       in   1             synchronous active-high reset; no asynchronous reset
// req_en     in   NREQ          per-requester enable, held until its req_ready pulse
// req_wr     in   NREQ          per-requester write (1) / read (0)
// req_addr   in   NREQ*ADDRW    flattened addresses, requester i at [i*ADDRW +: ADDRW]
// req_wdata  in   NREQ*XLEN     flattened write data
// req_strb   in   NREQ*XLEN/8   flattened byte strobes
// req_ready  out  NREQ          one-cycle completion pulse, one-hot or zero
// req_rdata  out  XLEN          read data, valid only while a req_ready bit is high, else 0
// mst_en     out  1             to interconnect slv_en
// mst_wr     out  1             to interconnect slv_wr
// mst_addr   out  ADDRW         to interconnect slv_addr
// mst_wdata  out  XLEN          to interconnect slv_wdata
// mst_strb   out  XLEN/8        to interconnect slv_strb
// mst_rdata  in   XLEN          from interconnect slv_rdata
// mst_ready  in   1             from interconnect slv_ready, one-cycle pulse
//
// BEHAVIOUR
// - Reset (srst sampled high): all outputs 0, state IDLE, rr pointer 0. Takes priority over
//   every other event, including mid-transfer; any in-flight transfer is abandoned with no
//   req_ready pulse.
// - FSM:
//   IDLE: if |req_en, pick winner g = first set req_en at or after pointer, wrapping modulo
//     NREQ. Register g; load mst_* from requester g; mst_en<=1; go to ACCESS.
//     If no req_en, stay in IDLE with all mst_* at 0.
//   ACCESS: hold mst_* stable, ignoring every req_* input including a withdrawn req_en[g].
//     On mst_ready: mst_en/wr/addr/wdata/strb<=0; req_ready[g]<=1; req_rdata<=mst_rdata;
//     pointer<=(g+1)%NREQ; go to RELEASE.
//   RELEASE: req_ready<=0, req_rdata<=0, go to IDLE. No arbitration here, because the
//     requester still shows req_en during its ready cycle. This also guarantees mst_en low
//     for at least 1 cycle between transfers, as the interconnect requires.
// - Latency: req_en rising at cycle 0 in IDLE gives mst_en=1 at cycle 1.
//   mst_ready=1 at cycle k gives req_ready=1 at cycle k+1, which is a single cycle.
//   Minimum inter-transfer gap on mst_en: 2 low cycles (RELEASE, IDLE).
// - Simultaneous requests: exactly one winner per arbitration. A requester that just
//   completed has lowest priority at the next arbitration, so there is no starvation.
//   Worst-case wait is NREQ-1 transfers.
// - Pointer wrap: winner NREQ-1 sets pointer to 0.
// - mst_ready seen outside ACCESS is ignored.
// - Arithmetic: grant index width $clog2(NREQ); modulo done by compare-and-wrap, not '%'
//   on non-power-of-two.
//
// STRUCTURE
// - friscv_h.sv: add the arbiter FSM state enum (IDLE/ACCESS/RELEASE, 2 bits) and the
//   NREQ_MAX=8 constant.
// - Sub-module friscv_rr_picker: combinational round-robin picker; inputs req[NREQ] and
//   ptr; outputs grant index and a valid flag.
// - The top holds the FSM, the registered mux and the pointer.
//
// TESTING
// 1. Single read: NREQ=2; req_en[0]=1, addr 0x0004; slave returns mst_ready with rdata
//    0xDEADBEEF 3 cycles later -> mst_en high cycles 1-3, mst_addr=0x0004,
//    req_ready=2'b01 with req_rdata=0xDEADBEEF for exactly 1 cycle.
// 2. Contention: req_en=2'b11 together, pointer 0 -> req0 served first, then req1.
//    Re-raising req0 right after does not preempt req1; grant order 0,1,0,1.
// 3. Write passthrough: req1 write addr 0x0010, wdata 0x12345678, strb 4'b0011 ->
//    identical values on mst_*; req_rdata stays 0 during the ready pulse.
// 4. Reset mid-transfer: srst at cycle 2 of ACCESS -> next cycle all outputs 0, no
//    req_ready; the following arbitration starts from pointer 0.
// 5. Wrap and gap: NREQ=3, all requesting continuously -> grants 0,1,2,0. mst_en low for
//    >=2 cycles between transfers. A spurious mst_ready in IDLE gives no req_ready.

Source files
------------

// File: rtl/friscv_apb_arbiter_pkg.sv
// Shared types and limits for the APB requester arbiter.
package friscv_apb_arbiter_pkg;

    localparam int NREQ_MAX = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/friscv_apb_arbiter_if.sv
// Requester-side and interconnect-side bus bundle of the APB arbiter.
interface friscv_apb_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int ADDRW = 16,
    parameter int XLEN  = 32
);
    logic [NREQ-1:0]          req_en;
    logic [NREQ-1:0]          req_wr;
    logic [NREQ*ADDRW-1:0]    req_addr;
    logic [NREQ*XLEN-1:0]     req_wdata;
    logic [NREQ*XLEN/8-1:0]   req_strb;
    logic [NREQ-1:0]          req_ready;
    logic [XLEN-1:0]          req_rdata;

    logic                     mst_en;
    logic                     mst_wr;
    logic [ADDRW-1:0]         mst_addr;
    logic [XLEN-1:0]          mst_wdata;
    logic [XLEN/8-1:0]        mst_strb;
    logic [XLEN-1:0]          mst_rdata;
    logic                     mst_ready;

    // Arbiter view: serves the requesters, masters the interconnect.
    modport master (
        input  req_en, req_wr, req_addr, req_wdata, req_strb,
        output req_ready, req_rdata,
        output mst_en, mst_wr, mst_addr, mst_wdata, mst_strb,
        input  mst_rdata, mst_ready
    );

    modport slave (
        output req_en, req_wr, req_addr, req_wdata, req_strb,
        input  req_ready, req_rdata,
        input  mst_en, mst_wr, mst_addr, mst_wdata, mst_strb,
        output mst_rdata, mst_ready
    );
endinterface

// File: rtl/friscv_apb_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module friscv_rr_picker #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [$clog2(NREQ)-1:0] grant_o,
    output logic                    valid_o
);
    localparam int IW = $clog2(NREQ);

    // Distance from the pointer decides priority; the nearest active request wins.
    always_comb begin
        int unsigned best;
        int unsigned off;
        best    = NREQ;
        off     = 0;
        grant_o = '0;
        valid_o = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            off = (i >= 32'(ptr_i)) ? i - 32'(ptr_i) : i + NREQ - 32'(ptr_i);
            if (req_i[i] && off < best) begin
                best    = off;
                grant_o = IW'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/friscv_apb_arbiter.sv
// Round-robin arbiter sharing one APB-like master port between NREQ requesters,
// one transfer in flight, all outputs registered.
module friscv_apb_arbiter
    import friscv_apb_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int ADDRW = 16,
    parameter int XLEN  = 32
) (
    input  logic                   aclk,
    input  logic                   srst,
    friscv_apb_arbiter_if.master   bus
);
    localparam int IW = $clog2(NREQ);
    localparam int SW = XLEN / 8;

    if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_nreq_chk
        $error("friscv_apb_arbiter: NREQ out of range");
    end

    arb_state_t         state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      gnt_q, gnt_d;
    logic [IW-1:0]      pick;
    logic               pick_vld;
    logic               mst_en_q, mst_en_d;
    logic               mst_wr_q, mst_wr_d;
    logic [ADDRW-1:0]   mst_addr_q, mst_addr_d;
    logic [XLEN-1:0]    mst_wdata_q, mst_wdata_d;
    logic [SW-1:0]      mst_strb_q, mst_strb_d;
    logic [NREQ-1:0]    req_ready_q, req_ready_d;
    logic [XLEN-1:0]    req_rdata_q, req_rdata_d;

    friscv_rr_picker #(.NREQ(NREQ)) u_picker (
        .req_i   (bus.req_en),
        .ptr_i   (ptr_q),
        .grant_o (pick),
        .valid_o (pick_vld)
    );

    always_ff @(posedge aclk) begin
        if (srst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            mst_en_q    <= 1'b0;
            mst_wr_q    <= 1'b0;
            mst_addr_q  <= '0;
            mst_wdata_q <= '0;
            mst_strb_q  <= '0;
            req_ready_q <= '0;
            req_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            mst_en_q    <= mst_en_d;
            mst_wr_q    <= mst_wr_d;
            mst_addr_q  <= mst_addr_d;
            mst_wdata_q <= mst_wdata_d;
            mst_strb_q  <= mst_strb_d;
            req_ready_q <= req_ready_d;
            req_rdata_q <= req_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_vld) state_d = ACCESS;
            ACCESS:  if (bus.mst_ready) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        mst_en_d    = mst_en_q;
        mst_wr_d    = mst_wr_q;
        mst_addr_d  = mst_addr_q;
        mst_wdata_d = mst_wdata_q;
        mst_strb_d  = mst_strb_q;
        req_ready_d = req_ready_q;
        req_rdata_d = req_rdata_q;
        case (state_q)
            IDLE: begin
                gnt_d       = pick;
                mst_en_d    = pick_vld;
                mst_wr_d    = 1'b0;
                mst_addr_d  = '0;
                mst_wdata_d = '0;
                mst_strb_d  = '0;
                for (int unsigned i = 0; i < NREQ; i++) begin
                    if (pick_vld && pick == IW'(i)) begin
                        mst_wr_d    = bus.req_wr[i];
                        mst_addr_d  = bus.req_addr[i*ADDRW +: ADDRW];
                        mst_wdata_d = bus.req_wdata[i*XLEN +: XLEN];
                        mst_strb_d  = bus.req_strb[i*SW +: SW];
                    end
                end
            end
            ACCESS: begin
                // Requester inputs are deliberately ignored until the slave completes.
                if (bus.mst_ready) begin
                    mst_en_d    = 1'b0;
                    mst_wr_d    = 1'b0;
                    mst_addr_d  = '0;
                    mst_wdata_d = '0;
                    mst_strb_d  = '0;
                    req_ready_d = NREQ'(1) << gnt_q;
                    req_rdata_d = bus.mst_rdata;
                    ptr_d       = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + IW'(1);
                end
            end
            RELEASE: begin
                req_ready_d = '0;
                req_rdata_d = '0;
            end
            default: ;
        endcase
    end

    assign bus.mst_en    = mst_en_q;
    assign bus.mst_wr    = mst_wr_q;
    assign bus.mst_addr  = mst_addr_q;
    assign bus.mst_wdata = mst_wdata_q;
    assign bus.mst_strb  = mst_strb_q;
    assign bus.req_ready = req_ready_q;
    assign bus.req_rdata = req_rdata_q;

endmodule

// File: tb/tb_friscv_apb_arbiter.sv
// Directed bench: a 2-requester arbiter for transfer/contention/reset cases and a
// 3-requester arbiter for pointer wrap and inter-transfer gap.
module tb_friscv_apb_arbiter;

    logic aclk;
    logic srst;
    int   checks;
    int   errors;

    friscv_apb_arbiter_if #(.NREQ(2), .ADDRW(16), .XLEN(32)) ifa ();
    friscv_apb_arbiter_if #(.NREQ(3), .ADDRW(16), .XLEN(32)) ifb ();

    friscv_apb_arbiter #(.NREQ(2), .ADDRW(16), .XLEN(32)) u_dut_a (
        .aclk (aclk),
        .srst (srst),
        .bus  (ifa)
    );

    friscv_apb_arbiter #(.NREQ(3), .ADDRW(16), .XLEN(32)) u_dut_b (
        .aclk (aclk),
        .srst (srst),
        .bus  (ifb)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Acts as the slave for one transfer on arbiter A and checks what it sees.
    task automatic serve_a(input int g, input logic [15:0] addr, input logic wr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input logic [31:0] rd);
        int n;
        n = 0;
        while (!ifa.mst_en && n < 10) begin
            tick();
            n++;
        end
        check_eq("a_en_wait", ifa.mst_en, 1);
        check_eq("a_addr", ifa.mst_addr, addr);
        check_eq("a_wr", ifa.mst_wr, wr);
        check_eq("a_wdata", ifa.mst_wdata, wdata);
        check_eq("a_strb", ifa.mst_strb, strb);
        ifa.mst_ready = 1'b1;
        ifa.mst_rdata = rd;
        tick();
        ifa.mst_ready = 1'b0;
        ifa.mst_rdata = '0;
        check_eq("a_ready", ifa.req_ready, 64'd1 << g);
        check_eq("a_rdata", ifa.req_rdata, rd);
        check_eq("a_en_low", ifa.mst_en, 0);
        ifa.req_en[g] = 1'b0;
    endtask

    initial begin
        int exp_g [4];
        int n;
        int gap;
        exp_g = '{0, 1, 2, 0};
        checks = 0;
        errors = 0;
        srst = 1'b1;
        ifa.req_en = '0; ifa.req_wr = '0; ifa.req_addr = '0; ifa.req_wdata = '0;
        ifa.req_strb = '0; ifa.mst_rdata = '0; ifa.mst_ready = 1'b0;
        ifb.req_en = '0; ifb.req_wr = '0; ifb.req_addr = '0; ifb.req_wdata = '0;
        ifb.req_strb = '0; ifb.mst_rdata = '0; ifb.mst_ready = 1'b0;
        tick();
        tick();
        srst = 1'b0;

        check_eq("rst_en", ifa.mst_en, 0);
        check_eq("rst_ready", ifa.req_ready, 0);
        check_eq("rst_rdata", ifa.req_rdata, 0);
        check_eq("rst_addr", ifa.mst_addr, 0);
        check_eq("rst_b_en", ifb.mst_en, 0);

        // Single read with a withdrawn request and changed address mid-access.
        ifa.req_en = 2'b01;
        ifa.req_addr[15:0] = 16'h0004;
        tick();
        check_eq("t1_c1_en", ifa.mst_en, 1);
        check_eq("t1_c1_addr", ifa.mst_addr, 16'h0004);
        check_eq("t1_c1_wr", ifa.mst_wr, 0);
        ifa.req_addr[15:0] = 16'h00FF;
        ifa.req_en = 2'b00;
        tick();
        check_eq("t1_c2_en", ifa.mst_en, 1);
        check_eq("t1_c2_addr", ifa.mst_addr, 16'h0004);
        tick();
        check_eq("t1_c3_en", ifa.mst_en, 1);
        ifa.mst_ready = 1'b1;
        ifa.mst_rdata = 32'hDEADBEEF;
        tick();
        ifa.mst_ready = 1'b0;
        ifa.mst_rdata = '0;
        check_eq("t1_c4_ready", ifa.req_ready, 2'b01);
        check_eq("t1_c4_rdata", ifa.req_rdata, 32'hDEADBEEF);
        check_eq("t1_c4_en", ifa.mst_en, 0);
        tick();
        check_eq("t1_c5_ready", ifa.req_ready, 0);
        check_eq("t1_c5_rdata", ifa.req_rdata, 0);
        check_eq("t1_c5_en", ifa.mst_en, 0);

        // Contention from pointer 0: grant order 0,1,0,1.
        srst = 1'b1;
        tick();
        srst = 1'b0;
        ifa.req_addr = {16'h0200, 16'h0100};
        ifa.req_en = 2'b11;
        serve_a(0, 16'h0100, 1'b0, 32'h0, 4'h0, 32'h1111_0000);
        tick();
        ifa.req_en[0] = 1'b1;
        serve_a(1, 16'h0200, 1'b0, 32'h0, 4'h0, 32'h2222_0000);
        tick();
        ifa.req_en[1] = 1'b1;
        serve_a(0, 16'h0100, 1'b0, 32'h0, 4'h0, 32'h3333_0000);
        serve_a(1, 16'h0200, 1'b0, 32'h0, 4'h0, 32'h4444_0000);
        ifa.req_en = '0;
        tick();

        // Write passthrough from requester 1; slave returns zero read data.
        ifa.req_wr = 2'b10;
        ifa.req_addr[31:16] = 16'h0010;
        ifa.req_wdata[63:32] = 32'h12345678;
        ifa.req_strb[7:4] = 4'b0011;
        ifa.req_en = 2'b10;
        serve_a(1, 16'h0010, 1'b1, 32'h12345678, 4'b0011, 32'h0);
        ifa.req_wr = '0;
        ifa.req_wdata = '0;
        ifa.req_strb = '0;
        ifa.req_addr[31:16] = 16'h0200;
        tick();

        // Reset in the second ACCESS cycle, racing a slave completion.
        ifa.req_en = 2'b01;
        serve_a(0, 16'h0100, 1'b0, 32'h0, 4'h0, 32'hA5A5_0001);
        tick();
        ifa.req_en = 2'b11;
        n = 0;
        while (!ifa.mst_en && n < 10) begin
            tick();
            n++;
        end
        check_eq("t4_en", ifa.mst_en, 1);
        check_eq("t4_addr_ptr1", ifa.mst_addr, 16'h0200);
        tick();
        check_eq("t4_c2_en", ifa.mst_en, 1);
        srst = 1'b1;
        ifa.mst_ready = 1'b1;
        ifa.mst_rdata = 32'hCAFE_F00D;
        tick();
        srst = 1'b0;
        ifa.mst_ready = 1'b0;
        ifa.mst_rdata = '0;
        check_eq("t4_rst_en", ifa.mst_en, 0);
        check_eq("t4_rst_addr", ifa.mst_addr, 0);
        check_eq("t4_rst_ready", ifa.req_ready, 0);
        check_eq("t4_rst_rdata", ifa.req_rdata, 0);
        tick();
        check_eq("t4_rearb_en", ifa.mst_en, 1);
        check_eq("t4_rearb_addr", ifa.mst_addr, 16'h0100);
        serve_a(0, 16'h0100, 1'b0, 32'h0, 4'h0, 32'hA5A5_0002);
        ifa.req_en = '0;
        tick();

        // Spurious slave ready in IDLE on arbiter B.
        ifb.mst_ready = 1'b1;
        ifb.mst_rdata = 32'h0BAD_0BAD;
        tick();
        ifb.mst_ready = 1'b0;
        ifb.mst_rdata = '0;
        check_eq("t5_spur_ready", ifb.req_ready, 0);
        check_eq("t5_spur_rdata", ifb.req_rdata, 0);
        tick();
        check_eq("t5_spur_en", ifb.mst_en, 0);

        // Continuous requests on three requesters: wrap and two-cycle gap.
        ifb.req_addr = {16'h1002, 16'h1001, 16'h1000};
        ifb.req_en = 3'b111;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            gap = 0;
            while (!ifb.mst_en && n < 10) begin
                gap++;
                tick();
                n++;
            end
            check_eq("t5_en_wait", ifb.mst_en, 1);
            if (k > 0) check_eq("t5_gap", gap, 2);
            check_eq("t5_addr", ifb.mst_addr, 16'h1000 + exp_g[k]);
            ifb.mst_ready = 1'b1;
            ifb.mst_rdata = 32'hB000_0000 + k;
            tick();
            ifb.mst_ready = 1'b0;
            ifb.mst_rdata = '0;
            check_eq("t5_ready", ifb.req_ready, 64'd1 << exp_g[k]);
            check_eq("t5_rdata", ifb.req_rdata, 32'hB000_0000 + k);
        end
        ifb.req_en = '0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
